// File: rtl/lc4_io_pkg.sv
// Shared LC4 I/O definitions: device addresses, KBSR bit positions and the
// keyboard capture-FSM state type.
package lc4_io_pkg;

    localparam logic [15:0] DEF_KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] DEF_KBDR_ADDR = 16'hFE02;

    localparam int KBSR_RDY_BIT = 15;
    localparam int KBSR_OVF_BIT = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PUSH   = 2'd2
    } kbd_state_t;

endpackage

// File: rtl/Nbit_reg.sv
// Generic N-bit register with synchronous reset, local write enable and
// global write enable.
module Nbit_reg #(
    parameter int             N           = 8,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_gwe,
    input  logic         i_we,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    // Reset wins over gwe; otherwise load only when both enables are high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RESET_VALUE;
        end else if (i_gwe && i_we) begin
            o_q <= i_d;
        end else begin
            o_q <= o_q;
        end
    end

endmodule

// File: rtl/kbd_fifo.sv
// Synchronous character FIFO built from Nbit_reg storage; a pop at full frees
// the slot that a simultaneous push then uses.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gwe,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    w_rptr;
    logic [AW-1:0]    w_wptr;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_nxt;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [WIDTH-1:0] w_mem [DEPTH];

    assign o_empty   = (w_count == '0);
    assign w_full    = (w_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign o_drop    = i_push && !w_push_ok;

    // Occupancy moves only when exactly one of push/pop is accepted.
    always_comb begin
        w_count_nxt = w_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = w_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = w_count - CW'(1);
        end else begin
            w_count_nxt = w_count;
        end
    end

    Nbit_reg #(.N(AW)) u_rptr (
        .i_clk(i_clk), .i_rst(i_rst), .i_gwe(i_gwe), .i_we(w_pop_ok),
        .i_d(w_rptr + AW'(1)), .o_q(w_rptr)
    );

    Nbit_reg #(.N(AW)) u_wptr (
        .i_clk(i_clk), .i_rst(i_rst), .i_gwe(i_gwe), .i_we(w_push_ok),
        .i_d(w_wptr + AW'(1)), .o_q(w_wptr)
    );

    Nbit_reg #(.N(CW)) u_count (
        .i_clk(i_clk), .i_rst(i_rst), .i_gwe(i_gwe), .i_we(w_push_ok ^ w_pop_ok),
        .i_d(w_count_nxt), .o_q(w_count)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        Nbit_reg #(.N(WIDTH)) u_slot (
            .i_clk(i_clk), .i_rst(i_rst), .i_gwe(i_gwe),
            .i_we(w_push_ok && (w_wptr == AW'(g))),
            .i_d(i_data), .o_q(w_mem[g])
        );
    end

    assign o_head = w_mem[w_rptr];

endmodule

// File: rtl/kbd_io_ctrl.sv
// Memory-mapped keyboard controller: settle-delayed key capture into a FIFO,
// KBSR/KBDR read decode. Optional sticky overflow flag: KBD_OVF_FLAG_EN.
module kbd_io_ctrl
    import lc4_io_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          SETTLE_CYC = 3,
    parameter logic [15:0] KBSR_ADDR  = DEF_KBSR_ADDR,
    parameter logic [15:0] KBDR_ADDR  = DEF_KBDR_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic        key_pressed,
    input  logic [7:0]  ascii,
    input  logic [15:0] addr,
    input  logic        re,
    output logic [15:0] dout,
    output logic        sel,
    output logic        kbsr_ready
);

    kbd_state_t r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_last;
    logic       w_is_kbsr;
    logic       w_is_kbdr;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_drop;
    logic       w_ovf;
    logic [7:0] w_head;

    assign w_is_kbsr = (addr == KBSR_ADDR);
    assign w_is_kbdr = (addr == KBDR_ADDR);
    assign w_push    = (r_state == ST_PUSH);
    assign w_pop     = re && w_is_kbdr && !w_empty;

    kbd_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .i_clk(clk), .i_rst(rst), .i_gwe(gwe),
        .i_push(w_push), .i_pop(re && w_is_kbdr), .i_data(ascii),
        .o_head(w_head), .o_empty(w_empty), .o_drop(w_drop)
    );

    // Capture FSM: one key in flight; presses outside IDLE are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else if (gwe) begin
            case (r_state)
                ST_IDLE: begin
                    if (key_pressed) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= 4'(SETTLE_CYC - 1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_PUSH;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_PUSH: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    // Last popped character, returned by KBDR reads while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 8'h00;
        end else if (gwe && w_pop) begin
            r_last <= w_head;
        end else begin
            r_last <= r_last;
        end
    end

`ifdef KBD_OVF_FLAG_EN
    logic r_ovf;

    // Sticky overflow: a drop in the same cycle as a KBSR read keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (gwe && w_drop) begin
            r_ovf <= 1'b1;
        end else if (gwe && re && w_is_kbsr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign w_ovf = r_ovf;
`else
    logic w_unused_drop;

    assign w_unused_drop = w_drop;
    assign w_ovf         = 1'b0;
`endif

    // Zero-latency read mux onto the memory bus.
    always_comb begin
        dout = 16'h0000;
        if (w_is_kbsr) begin
            dout[KBSR_RDY_BIT] = !w_empty;
            dout[KBSR_OVF_BIT] = w_ovf;
        end else if (w_is_kbdr) begin
            dout = {8'h00, (w_empty ? r_last : w_head)};
        end else begin
            dout = 16'h0000;
        end
    end

    assign sel        = w_is_kbsr || w_is_kbdr;
    assign kbsr_ready = !w_empty;

endmodule

// File: tb/tb_kbd_io_ctrl.sv
// Self-checking bench for kbd_io_ctrl against a queue-based behavioural model.
module tb_kbd_io_ctrl;

    localparam int          DEPTH = 4;
    localparam int          S     = 3;
    localparam logic [15:0] KBSR  = 16'hFE00;
    localparam logic [15:0] KBDR  = 16'hFE02;
    localparam logic [15:0] OTHER = 16'h1234;
`ifdef KBD_OVF_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gwe = 1'b1;
    logic        key_pressed = 1'b0;
    logic [7:0]  ascii = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic        re = 1'b0;
    logic [15:0] dout;
    logic        sel;
    logic        kbsr_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_q [$];
    logic [7:0]  m_last = 8'h00;
    logic        m_ovf  = 1'b0;
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [15:0] exp_dout;
    logic        exp_sel;
    logic        exp_rdy;

    always #5 clk = ~clk;

    kbd_io_ctrl dut (
        .clk(clk), .rst(rst), .gwe(gwe), .key_pressed(key_pressed),
        .ascii(ascii), .addr(addr), .re(re),
        .dout(dout), .sel(sel), .kbsr_ready(kbsr_ready)
    );

    // Apply inputs after the falling edge and compute what the model expects.
    task automatic drive(input logic k, input logic [7:0] ch, input logic [15:0] a,
                         input logic r, input logic g, input logic rs);
        @(negedge clk);
        key_pressed = k; ascii = ch; addr = a; re = r; gwe = g; rst = rs;
        #1;
        exp_sel = (a == KBSR) || (a == KBDR);
        exp_rdy = (m_q.size() != 0);
        if (a == KBSR)      exp_dout = {exp_rdy, OVF_EN & m_ovf, 14'h0000};
        else if (a == KBDR) exp_dout = {8'h00, (exp_rdy ? m_q[0] : m_last)};
        else                exp_dout = 16'h0000;
    endtask

    // Advance one clock and apply the behavioural rules to the model.
    task automatic tick();
        logic drop;
        @(posedge clk);
        drop = 1'b0;
        if (rst) begin
            m_q.delete(); m_last = 8'h00; m_ovf = 1'b0; m_busy = 1'b0; m_left = 0;
        end else if (gwe) begin
            if (re && addr == KBDR && m_q.size() > 0) m_last = m_q.pop_front();
            if (m_busy && m_left == 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(ascii);
                else drop = 1'b1;
            end
            if (re && addr == KBSR) m_ovf = 1'b0;
            if (drop) m_ovf = 1'b1;
            if (m_busy) begin
                if (m_left == 0) m_busy = 1'b0;
                else m_left--;
            end else if (key_pressed) begin
                m_busy = 1'b1; m_left = S;
            end
        end
    endtask

    task automatic idle(input int n, input logic [7:0] ch);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, ch, OTHER, 1'b0, 1'b1, 1'b0); tick();
        end
    endtask

    task automatic key_in(input logic [7:0] ch);
        drive(1'b1, ch, OTHER, 1'b0, 1'b1, 1'b0); tick();
        idle(S + 1, ch);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, OTHER, 1'b0, 1'b1, 1'b1); tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h5A, KBSR, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h5A, KBDR, 1'b1, 1'b1, 1'b1); tick();
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0000 || kbsr_ready !== 1'b0 || sel !== 1'b1) begin
            n_fail++; $display("FAIL reset_kbsr: got dout=%h rdy=%b sel=%b, exp 0000/0/1", dout, kbsr_ready, sel);
        end
        tick();
        drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0000) begin
            n_fail++; $display("FAIL reset_kbdr: got %h exp 0000", dout);
        end
        tick();
        drive(1'b0, 8'h00, OTHER, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0000 || sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_other: got dout=%h sel=%b exp 0000/0", dout, sel);
        end
        tick();
        idle(S + 3, 8'h00);
        drive(1'b0, 8'h00, OTHER, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (kbsr_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort: got rdy=%b exp 0", kbsr_ready);
        end
        tick();
    endtask

    task automatic test_single_key();
        do_reset();
        drive(1'b1, 8'h41, OTHER, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 8'h41, OTHER, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (kbsr_ready !== (i >= 5) || kbsr_ready !== exp_rdy) begin
                n_fail++; $display("FAIL single_latency: cycle+%0d got rdy=%b exp %b", i, kbsr_ready, (i >= 5));
            end
            tick();
        end
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h8000) begin n_fail++; $display("FAIL single_kbsr: got %h exp 8000", dout); end
        tick();
        drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0041) begin n_fail++; $display("FAIL single_kbdr: got %h exp 0041", dout); end
        tick();
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0000) begin n_fail++; $display("FAIL single_kbsr_empty: got %h exp 0000", dout); end
        tick();
        drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0041) begin n_fail++; $display("FAIL single_kbdr_last: got %h exp 0041", dout); end
        tick();
    endtask

    task automatic test_burst();
        do_reset();
        for (int k = 0; k < 4; k++) key_in(8'h61 + 8'(k));
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (dout !== {8'h00, 8'h61 + 8'(k)} || kbsr_ready !== 1'b1) begin
                n_fail++; $display("FAIL burst_pop%0d: got %h rdy=%b exp %h rdy=1", k, dout, kbsr_ready, {8'h00, 8'h61 + 8'(k)});
            end
            tick();
        end
        drive(1'b0, 8'h00, OTHER, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (kbsr_ready !== 1'b0) begin n_fail++; $display("FAIL burst_empty: got rdy=%b exp 0", kbsr_ready); end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 5; k++) key_in(8'h30 + 8'(k));
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== (OVF_EN ? 16'hC000 : 16'h8000)) begin
            n_fail++; $display("FAIL ovf_set: got %h exp %h", dout, (OVF_EN ? 16'hC000 : 16'h8000));
        end
        tick();
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h8000) begin n_fail++; $display("FAIL ovf_clear: got %h exp 8000", dout); end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (dout !== {8'h00, 8'h30 + 8'(k)}) begin
                n_fail++; $display("FAIL ovf_pop%0d: got %h exp %h", k, dout, {8'h00, 8'h30 + 8'(k)});
            end
            tick();
        end
        drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0033 || kbsr_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_fifth_absent: got %h rdy=%b exp 0033 rdy=0", dout, kbsr_ready);
        end
        tick();
    endtask

    task automatic test_full_simul();
        logic [7:0] exp_chars [5];
        exp_chars = '{8'h77, 8'h78, 8'h79, 8'h7A, 8'h21};
        do_reset();
        for (int k = 0; k < 4; k++) key_in(exp_chars[k]);
        drive(1'b1, 8'h21, OTHER, 1'b0, 1'b1, 1'b0); tick();
        idle(S, 8'h21);
        drive(1'b0, 8'h21, KBDR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0077) begin n_fail++; $display("FAIL full_simul_pop: got %h exp 0077", dout); end
        tick();
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h8000) begin n_fail++; $display("FAIL full_simul_kbsr: got %h exp 8000", dout); end
        tick();
        for (int k = 1; k < 5; k++) begin
            drive(1'b0, 8'h00, KBDR, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (dout !== {8'h00, exp_chars[k]} || dout !== exp_dout) begin
                n_fail++; $display("FAIL full_simul_pop%0d: got %h exp %h", k, dout, {8'h00, exp_chars[k]});
            end
            tick();
        end
        drive(1'b0, 8'h00, OTHER, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (kbsr_ready !== 1'b0) begin n_fail++; $display("FAIL full_simul_empty: got rdy=%b exp 0", kbsr_ready); end
        tick();
    endtask

    task automatic test_gwe_low();
        do_reset();
        key_in(8'h67);
        drive(1'b1, 8'h55, OTHER, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < S + 3; i++) begin
            drive(1'b0, 8'h55, KBDR, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (dout !== 16'h0067 || kbsr_ready !== 1'b1) begin
                n_fail++; $display("FAIL gwe_hold%0d: got %h rdy=%b exp 0067 rdy=1", i, dout, kbsr_ready);
            end
            tick();
        end
        drive(1'b0, 8'h55, KBDR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0067) begin n_fail++; $display("FAIL gwe_pop: got %h exp 0067", dout); end
        tick();
        idle(S + 2, 8'h55);
        drive(1'b0, 8'h00, KBSR, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 16'h0000) begin n_fail++; $display("FAIL gwe_key_ignored: got %h exp 0000", dout); end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0:       a = KBSR;
                1:       a = KBDR;
                default: a = 16'($urandom_range(0, 65535));
            endcase
            drive(($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)), a,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 299) == 0));
            n_tests++;
            if ({sel, kbsr_ready, dout} !== {exp_sel, exp_rdy, exp_dout}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got sel=%b rdy=%b dout=%h exp sel=%b rdy=%b dout=%h",
                         i, sel, kbsr_ready, dout, exp_sel, exp_rdy, exp_dout);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_burst();
        test_overflow();
        test_full_simul();
        test_gwe_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
